// File: rtl/lector_contador.sv
// lector_contador: sweeps the push-counter query port over idx 0..NUM_FIFOS-1 and holds every count.
// Defining LECTOR_TOTAL_EN adds a registered 9-bit `total` output, the sum of the captured counts.
module lector_contador #(
  parameter int NUM_FIFOS = 5,
  parameter int DATA_W    = 6,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              start,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              req,
  output logic [2:0]        idx,
  output logic [DATA_W-1:0] cnt0,
  output logic [DATA_W-1:0] cnt1,
  output logic [DATA_W-1:0] cnt2,
  output logic [DATA_W-1:0] cnt3,
  output logic [DATA_W-1:0] cnt4,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef LECTOR_TOTAL_EN
  ,
  output logic [8:0]        total
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] K_LAST = 3'(NUM_FIFOS - 1);
  localparam logic [7:0] W_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [7:0]        w_q, w_d;
  logic              req_q, req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] cnt_q [NUM_FIFOS];
  logic [DATA_W-1:0] cnt_d [NUM_FIFOS];

  // Next-state and next-output logic for the poll sweep.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    w_d     = w_q;
    req_d   = req_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      cnt_d[i] = cnt_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        req_d = 1'b0;
        if (start) begin
          k_d     = 3'd0;
          w_d     = 8'd0;
          err_d   = 1'b0;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        // A response in the timeout cycle still counts as a good capture.
        if (valid) begin
          cnt_d[k_q] = data;
          w_d        = 8'd0;
          req_d      = 1'b0;
          state_d    = ST_GAP;
        end else if (w_q == W_LAST) begin
          cnt_d[k_q] = {DATA_W{1'b0}};
          err_d      = 1'b1;
          w_d        = 8'd0;
          req_d      = 1'b0;
          state_d    = ST_GAP;
        end else begin
          w_d     = w_q + 8'd1;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_GAP: begin
        if (k_q == K_LAST) begin
          req_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + 3'd1;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_DONE: begin
        req_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sweep state, index, wait counter, captured counts and status flags.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_IDLE;
      k_q     <= 3'd0;
      w_q     <= 8'd0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_FIFOS; i++) begin
        cnt_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      w_q     <= w_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      for (int i = 0; i < NUM_FIFOS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef LECTOR_TOTAL_EN
  logic [8:0] total_q, total_d;

  // Sum is formed in the last GAP cycle so it lands together with done.
  always_comb begin
    total_d = total_q;
    if (state_q == ST_GAP && k_q == K_LAST) begin
      total_d = 9'd0;
      for (int i = 0; i < NUM_FIFOS; i++) begin
        total_d = total_d + 9'(cnt_q[i]);
      end
    end else begin
      total_d = total_q;
    end
  end

  // Holding register for the sweep total.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      total_q <= 9'd0;
    end else begin
      total_q <= total_d;
    end
  end

  assign total = total_q;
`endif

  assign req  = req_q;
  assign idx  = k_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];
  assign cnt4 = cnt_q[4];

endmodule

// File: tb/tb_lector_contador.sv
// Directed bench for lector_contador: counter model answering the query port, per-scenario check tasks.
module tb_lector_contador;

  logic       clk = 1'b0;
  logic       reset_L = 1'b1;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic [5:0] data = 6'd0;
  logic       req, busy, done, err;
  logic [2:0] idx;
  logic [5:0] cnt0, cnt1, cnt2, cnt3, cnt4;
`ifdef LECTOR_TOTAL_EN
  logic [8:0] total;
`endif
  logic [5:0] cnt_w [5];

  int n_total = 0;
  int n_bad = 0;

  // counter model controls
  logic [5:0] mdl_cnt [5];
  int         mdl_dly [5];
  int         never_idx = -1;
  bit         spur_en = 1'b0;
  int         hi_cnt = 0;

  // sweep observations
  int done_cyc, busy_n, rise_n, idx_unstable;
  int seq [8];
  int reqhi [5];
  logic first_req, first_busy, prev_req;
  logic [2:0] first_idx, prev_idx;

  lector_contador #(.NUM_FIFOS(5), .DATA_W(6), .TIMEOUT(15)) dut (
    .clk(clk), .reset_L(reset_L), .start(start), .valid(valid), .data(data),
    .req(req), .idx(idx),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3), .cnt4(cnt4),
    .busy(busy), .done(done), .err(err)
`ifdef LECTOR_TOTAL_EN
    , .total(total)
`endif
  );

  assign cnt_w[0] = cnt0;
  assign cnt_w[1] = cnt1;
  assign cnt_w[2] = cnt2;
  assign cnt_w[3] = cnt3;
  assign cnt_w[4] = cnt4;

  always #5 clk = ~clk;

  // Counter model: answers mdl_dly cycles after req rises; optional spurious valid while in GAP.
  always @(posedge clk) begin
    #1;
    if (req) hi_cnt = hi_cnt + 1; else hi_cnt = 0;
    valid = 1'b0;
    data  = 6'd0;
    if (req && idx < 3'd5) begin
      if (int'(idx) != never_idx && hi_cnt == mdl_dly[idx] + 1) begin
        valid = 1'b1;
        data  = mdl_cnt[idx];
      end
    end else if (spur_en && !req && busy) begin
      valid = 1'b1;
      data  = 6'd42;
    end
  end

  task automatic load(input int a, input int b, input int c, input int d, input int e);
    mdl_cnt[0] = 6'(a); mdl_cnt[1] = 6'(b); mdl_cnt[2] = 6'(c);
    mdl_cnt[3] = 6'(d); mdl_cnt[4] = 6'(e);
    for (int i = 0; i < 5; i++) mdl_dly[i] = 1;
    never_idx = -1;
    spur_en = 1'b0;
  endtask

  // Cycle 1 is the cycle after the edge that samples start; returns once done is seen.
  task automatic run_sweep(input bit pre, input int restart_cyc);
    if (!pre) begin
      @(posedge clk); #1; start = 1'b1;
    end
    @(posedge clk); #1; start = 1'b0;
    done_cyc = -1; busy_n = 0; rise_n = 0; idx_unstable = 0;
    prev_req = 1'b0; prev_idx = 3'd0;
    for (int i = 0; i < 5; i++) reqhi[i] = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) begin
        first_req = req; first_idx = idx; first_busy = busy;
      end
      if (busy) busy_n++;
      if (req && !prev_req) begin
        if (rise_n < 8) seq[rise_n] = int'(idx);
        rise_n++;
      end
      if (req && idx < 3'd5) reqhi[idx] = reqhi[idx] + 1;
      if (req && prev_req && idx != prev_idx) idx_unstable++;
      prev_req = req;
      prev_idx = idx;
      if (c == restart_cyc) start = 1'b1; else start = 1'b0;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset_L = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", req); end
    n_total++; if (idx !== 3'd0) begin n_bad++; $display("FAIL reset_idx: got %0d want 0", idx); end
    n_total++; if ({busy, done, err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {busy, done, err}); end
    for (int i = 0; i < 5; i++) begin
      n_total++; if (cnt_w[i] !== 6'd0) begin n_bad++; $display("FAIL reset_cnt%0d: got %0d want 0", i, cnt_w[i]); end
    end
`ifdef LECTOR_TOTAL_EN
    n_total++; if (total !== 9'd0) begin n_bad++; $display("FAIL reset_total: got %0d want 0", total); end
`endif
    reset_L = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [5:0] exp [5];
    exp = '{6'd3, 6'd0, 6'd63, 6'd17, 6'd5};
    load(3, 0, 63, 17, 5);
    run_sweep(1'b0, 0);
    n_total++; if (first_req !== 1'b1 || first_idx !== 3'd0) begin n_bad++; $display("FAIL basic_first_req: got req=%b idx=%0d want req=1 idx=0", first_req, first_idx); end
    n_total++; if (first_busy !== 1'b1) begin n_bad++; $display("FAIL basic_first_busy: got %b want 1", first_busy); end
    n_total++; if (done_cyc !== 16) begin n_bad++; $display("FAIL basic_done_cyc: got %0d want 16", done_cyc); end
    n_total++; if (busy_n !== 15) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d want 15", busy_n); end
    n_total++; if (rise_n !== 5) begin n_bad++; $display("FAIL basic_req_rises: got %0d want 5", rise_n); end
    for (int i = 0; i < 5; i++) begin
      n_total++; if (seq[i] !== i) begin n_bad++; $display("FAIL basic_idx_seq%0d: got %0d want %0d", i, seq[i], i); end
      n_total++; if (cnt_w[i] !== exp[i]) begin n_bad++; $display("FAIL basic_cnt%0d: got %0d want %0d", i, cnt_w[i], exp[i]); end
    end
    n_total++; if (err !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %b want 0", err); end
`ifdef LECTOR_TOTAL_EN
    n_total++; if (total !== 9'd88) begin n_bad++; $display("FAIL basic_total: got %0d want 88", total); end
`endif
    @(negedge clk);
    n_total++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_timeout();
    logic [5:0] exp [5];
    exp = '{6'd10, 6'd20, 6'd0, 6'd40, 6'd50};
    load(10, 20, 30, 40, 50);
    never_idx = 2;
    run_sweep(1'b0, 0);
    n_total++; if (reqhi[2] !== 15) begin n_bad++; $display("FAIL timeout_req_cycles: got %0d want 15", reqhi[2]); end
    n_total++; if (done_cyc !== 29) begin n_bad++; $display("FAIL timeout_done_cyc: got %0d want 29", done_cyc); end
    n_total++; if (err !== 1'b1) begin n_bad++; $display("FAIL timeout_err: got %b want 1", err); end
    for (int i = 0; i < 5; i++) begin
      n_total++; if (cnt_w[i] !== exp[i]) begin n_bad++; $display("FAIL timeout_cnt%0d: got %0d want %0d", i, cnt_w[i], exp[i]); end
    end
    repeat (3) @(negedge clk);
    n_total++; if (err !== 1'b1) begin n_bad++; $display("FAIL timeout_err_hold: got %b want 1", err); end
  endtask

  task automatic test_delay();
    load(1, 2, 3, 4, 9);
    mdl_dly[4] = 7;
    run_sweep(1'b0, 0);
    // valid arrives 7 cycles after req rises, so req is high for 8 cycles
    n_total++; if (reqhi[4] !== 8) begin n_bad++; $display("FAIL delay_req_cycles: got %0d want 8", reqhi[4]); end
    n_total++; if (idx_unstable !== 0) begin n_bad++; $display("FAIL delay_idx_stable: got %0d changes want 0", idx_unstable); end
    n_total++; if (cnt4 !== 6'd9) begin n_bad++; $display("FAIL delay_cnt4: got %0d want 9", cnt4); end
    n_total++; if (err !== 1'b0) begin n_bad++; $display("FAIL delay_err: got %b want 0", err); end
    n_total++; if (done_cyc !== 22) begin n_bad++; $display("FAIL delay_done_cyc: got %0d want 22", done_cyc); end
  endtask

  task automatic test_ignore();
    logic [5:0] exp [5];
    exp = '{6'd3, 6'd0, 6'd63, 6'd17, 6'd5};
    load(3, 0, 63, 17, 5);
    spur_en = 1'b1;
    run_sweep(1'b0, 5);
    spur_en = 1'b0;
    n_total++; if (done_cyc !== 16) begin n_bad++; $display("FAIL ignore_done_cyc: got %0d want 16", done_cyc); end
    n_total++; if (rise_n !== 5) begin n_bad++; $display("FAIL ignore_req_rises: got %0d want 5", rise_n); end
    for (int i = 0; i < 5; i++) begin
      n_total++; if (cnt_w[i] !== exp[i]) begin n_bad++; $display("FAIL ignore_cnt%0d: got %0d want %0d", i, cnt_w[i], exp[i]); end
    end
    n_total++; if (err !== 1'b0) begin n_bad++; $display("FAIL ignore_err: got %b want 0", err); end
  endtask

  task automatic test_max();
    load(63, 63, 63, 63, 63);
    run_sweep(1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      n_total++; if (cnt_w[i] !== 6'd63) begin n_bad++; $display("FAIL max_cnt%0d: got %0d want 63", i, cnt_w[i]); end
    end
`ifdef LECTOR_TOTAL_EN
    n_total++; if (total !== 9'd315) begin n_bad++; $display("FAIL max_total: got %0d want 315", total); end
`endif
  endtask

  task automatic test_reset_mid();
    bit found;
    logic [5:0] exp [5];
    exp = '{6'd11, 6'd12, 6'd13, 6'd14, 6'd15};
    load(11, 12, 13, 14, 15);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (req && idx == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    n_total++; if (found !== 1'b1) begin n_bad++; $display("FAIL midrst_reach_idx3: got %b want 1", found); end
    reset_L = 1'b0;
    #1;
    n_total++; if (req !== 1'b0 || idx !== 3'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL midrst_async: got req=%b idx=%0d busy=%b want 0 0 0", req, idx, busy); end
    n_total++; if (cnt0 !== 6'd0 || cnt2 !== 6'd0) begin n_bad++; $display("FAIL midrst_cnt_clear: got cnt0=%0d cnt2=%0d want 0 0", cnt0, cnt2); end
    start = 1'b1;
    @(negedge clk);
    reset_L = 1'b1;
    run_sweep(1'b1, 0);
    n_total++; if (first_req !== 1'b1 || first_idx !== 3'd0) begin n_bad++; $display("FAIL midrst_first_req: got req=%b idx=%0d want 1 0", first_req, first_idx); end
    n_total++; if (done_cyc !== 16) begin n_bad++; $display("FAIL midrst_done_cyc: got %0d want 16", done_cyc); end
    for (int i = 0; i < 5; i++) begin
      n_total++; if (cnt_w[i] !== exp[i]) begin n_bad++; $display("FAIL midrst_cnt%0d: got %0d want %0d", i, cnt_w[i], exp[i]); end
    end
  endtask

  initial begin
    load(0, 0, 0, 0, 0);
    test_reset();
    test_basic();
    test_timeout();
    test_delay();
    test_ignore();
    test_max();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
